// File: rtl/blu_pkg.sv
// Shared types and helpers for the blu_inv inverse butterfly.
// BLU_INV_CHECK_EN (when defined) enables exactness checks in blu_inv.
package blu_pkg;

    typedef enum logic {
        BLU_MODE_GS = 1'b0,
        BLU_MODE_CT = 1'b1
    } blu_mode_e;

    typedef enum logic [2:0] {
        BLU_IDLE = 3'd0,
        BLU_PRE  = 3'd1,
        BLU_DIV1 = 3'd2,
        BLU_DIV2 = 3'd3,
        BLU_POST = 3'd4,
        BLU_DONE = 3'd5
    } blu_state_e;

    // One quotient bit per cycle over a 2W-bit dividend.
    function automatic int blu_div_cycles(input int width);
        return 2 * width;
    endfunction

    localparam int BLU_WIDTH  = 8;
    localparam int DIV_CYCLES = blu_div_cycles(BLU_WIDTH);

endpackage

// File: rtl/blu_seq_div.sv
// Radix-2 restoring divider: 2W-bit dividend, W-bit divisor, one bit per cycle.
// The start edge performs the first iteration, so a division spans 2W edges.
module blu_seq_div
    import blu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [2*WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]     divisor_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   quotient_o,
    output logic [WIDTH-1:0]     remainder_o
);

    localparam int CYCLES = blu_div_cycles(WIDTH);
    localparam int CW     = $clog2(CYCLES + 1);

    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [2*WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   step_rem_in;
    logic [2*WIDTH-1:0] step_quo_in;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   step_rem;
    logic [2*WIDTH-1:0] step_quo;

    // The dividend shifts out of the top of quo while quotient bits shift in.
    always_comb begin
        step_rem_in = start_i ? '0 : rem_q;
        step_quo_in = start_i ? dividend_i : quo_q;
        trial       = {step_rem_in, step_quo_in[2*WIDTH-1]};
        if (trial >= {1'b0, divisor_i}) begin
            step_rem = WIDTH'(trial - {1'b0, divisor_i});
            step_quo = {step_quo_in[2*WIDTH-2:0], 1'b1};
        end else begin
            step_rem = trial[WIDTH-1:0];
            step_quo = {step_quo_in[2*WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = done_q;
        if (start_i) begin
            rem_d  = step_rem;
            quo_d  = step_quo;
            cnt_d  = CW'(CYCLES - 1);
            busy_d = 1'b1;
            done_d = 1'b0;
        end else if (busy_q) begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/blu_inv.sv
// Inverse butterfly: recovers a, b from (x, y, q) for CT and GS butterflies.
// Define BLU_INV_CHECK_EN to flag inexact or out-of-range recoveries on err_o.
module blu_inv
    import blu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 ct_i,
    input  logic [2*WIDTH-1:0]   x_i,
    input  logic [2*WIDTH-1:0]   y_i,
    input  logic [WIDTH-1:0]     q_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     a_o,
    output logic [WIDTH-1:0]     b_o,
    output logic                 err_o
);

    localparam int W2 = 2 * WIDTH;

    blu_state_e        state_q, state_d;
    blu_mode_e         mode_q, mode_d;
    logic [W2-1:0]     x_q, x_d, y_q, y_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [W2-1:0]     sum_q, sum_d;
    logic [W2-1:0]     dvd1_q, dvd1_d, dvd2_q, dvd2_d;
    logic [W2-1:0]     s_q, s_d;
    logic              neg_q, neg_d;
    logic              odd_q, odd_d;
    logic              kick_q, kick_d;
    logic              rem1_nz_q, rem1_nz_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              err_q, err_d;

    logic              div_start;
    logic [W2-1:0]     div_dvd;
    logic              div_busy;
    logic              div_done;
    logic [W2-1:0]     div_quo;
    logic [WIDTH-1:0]  div_rem;

    logic [W2-1:0]     pre_sum, pre_dif;
    logic [W2-1:0]     quo_eff, s_eff, ct_a_full;
    logic signed [WIDTH+1:0] s_w, m_w, d_w, sum_sd, dif_sd, gs_a, gs_b;
    logic              q_zero;
    logic              chk_err;

    blu_seq_div #(.WIDTH(WIDTH)) u_div (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (div_start),
        .dividend_i  (div_dvd),
        .divisor_i   (q_q),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    // A zero twiddle still runs the divider for fixed latency, but its result is replaced by all-ones.
    always_comb begin
        pre_sum   = x_q + y_q;
        pre_dif   = x_q - y_q;
        q_zero    = (q_q == '0);
        quo_eff   = q_zero ? '1 : div_quo;
        s_eff     = q_zero ? '1 : s_q;
        ct_a_full = sum_q >> 1;
        s_w       = $signed({2'b00, s_eff[WIDTH-1:0]});
        m_w       = $signed({2'b00, quo_eff[WIDTH-1:0]});
        d_w       = neg_q ? -m_w : m_w;
        sum_sd    = s_w + d_w;
        dif_sd    = s_w - d_w;
        gs_a      = sum_sd >>> 1;
        gs_b      = dif_sd >>> 1;
    end

`ifdef BLU_INV_CHECK_EN
    always_comb begin
        if (mode_q == BLU_MODE_CT) begin
            chk_err = (|div_rem) | odd_q | (|div_quo[W2-1:WIDTH])
                    | (|ct_a_full[W2-1:WIDTH]);
        end else begin
            chk_err = rem1_nz_q | (|div_rem) | sum_sd[0]
                    | (|s_q[W2-1:WIDTH]) | (|div_quo[W2-1:WIDTH])
                    | (gs_a[WIDTH+1:WIDTH] != 2'b00)
                    | (gs_b[WIDTH+1:WIDTH] != 2'b00);
        end
    end
    logic unused_chk;
    assign unused_chk = ^{div_busy, dif_sd[0]};
`else
    assign chk_err = 1'b0;
    logic unused_chk;
    assign unused_chk = ^{div_busy, div_rem, rem1_nz_q, odd_q, s_q[W2-1:WIDTH],
                          div_quo[W2-1:WIDTH], ct_a_full[W2-1:WIDTH], sum_sd[0],
                          dif_sd[0], gs_a[WIDTH+1:WIDTH], gs_b[WIDTH+1:WIDTH]};
`endif

    // Dividends are registered in PRE; the divider is launched on the first DIV1 cycle (kick).
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        x_d       = x_q;
        y_d       = y_q;
        q_d       = q_q;
        sum_d     = sum_q;
        dvd1_d    = dvd1_q;
        dvd2_d    = dvd2_q;
        s_d       = s_q;
        neg_d     = neg_q;
        odd_d     = odd_q;
        kick_d    = 1'b0;
        rem1_nz_d = rem1_nz_q;
        a_d       = a_q;
        b_d       = b_q;
        err_d     = err_q;
        div_start = 1'b0;
        div_dvd   = dvd1_q;

        unique case (state_q)
            BLU_IDLE: begin
                if (in_valid_i) begin
                    mode_d  = ct_i ? BLU_MODE_CT : BLU_MODE_GS;
                    x_d     = x_i;
                    y_d     = y_i;
                    q_d     = q_i;
                    state_d = BLU_PRE;
                end
            end
            BLU_PRE: begin
                sum_d   = pre_sum;
                odd_d   = pre_sum[0] | pre_dif[0];
                dvd1_d  = (mode_q == BLU_MODE_CT) ? (pre_dif >> 1) : x_q;
                dvd2_d  = y_q[W2-1] ? -y_q : y_q;
                neg_d   = y_q[W2-1];
                kick_d  = 1'b1;
                state_d = BLU_DIV1;
            end
            BLU_DIV1: begin
                if (kick_q) begin
                    div_start = 1'b1;
                    div_dvd   = dvd1_q;
                end else if (div_done) begin
                    if (mode_q == BLU_MODE_CT) begin
                        state_d = BLU_POST;
                    end else begin
                        s_d       = div_quo;
                        rem1_nz_d = |div_rem;
                        div_start = 1'b1;
                        div_dvd   = dvd2_q;
                        state_d   = BLU_DIV2;
                    end
                end
            end
            BLU_DIV2: begin
                if (div_done) begin
                    state_d = BLU_POST;
                end
            end
            BLU_POST: begin
                if (mode_q == BLU_MODE_CT) begin
                    a_d = ct_a_full[WIDTH-1:0];
                    b_d = quo_eff[WIDTH-1:0];
                end else begin
                    a_d = gs_a[WIDTH-1:0];
                    b_d = gs_b[WIDTH-1:0];
                end
                err_d   = q_zero | chk_err;
                state_d = BLU_DONE;
            end
            BLU_DONE: begin
                if (out_ready_i) begin
                    state_d = BLU_IDLE;
                end
            end
            default: state_d = BLU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= BLU_IDLE;
            mode_q    <= BLU_MODE_GS;
            x_q       <= '0;
            y_q       <= '0;
            q_q       <= '0;
            sum_q     <= '0;
            dvd1_q    <= '0;
            dvd2_q    <= '0;
            s_q       <= '0;
            neg_q     <= 1'b0;
            odd_q     <= 1'b0;
            kick_q    <= 1'b0;
            rem1_nz_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            x_q       <= x_d;
            y_q       <= y_d;
            q_q       <= q_d;
            sum_q     <= sum_d;
            dvd1_q    <= dvd1_d;
            dvd2_q    <= dvd2_d;
            s_q       <= s_d;
            neg_q     <= neg_d;
            odd_q     <= odd_d;
            kick_q    <= kick_d;
            rem1_nz_q <= rem1_nz_d;
            a_q       <= a_d;
            b_q       <= b_d;
            err_q     <= err_d;
        end
    end

    assign in_ready_o  = (state_q == BLU_IDLE);
    assign out_valid_o = (state_q == BLU_DONE);
    assign a_o         = a_q;
    assign b_o         = b_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_blu_inv.sv
// Scoreboard bench for blu_inv (WIDTH=8): directed vectors with hand-computed results.
// Stimulus pushes expectations; an independent monitor checks latency and results.
module tb_blu_inv;

    localparam int W = 8;

`ifdef BLU_INV_CHECK_EN
    localparam logic ODD_ERR = 1'b1;
`else
    localparam logic ODD_ERR = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         err;
        int           lat;
        int           acc;
    } exp_t;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           in_valid_i;
    logic           in_ready_o;
    logic           ct_i;
    logic [2*W-1:0] x_i;
    logic [2*W-1:0] y_i;
    logic [W-1:0]   q_i;
    logic           out_valid_o;
    logic           out_ready_i;
    logic [W-1:0]   a_o;
    logic [W-1:0]   b_o;
    logic           err_o;

    exp_t exp_q[$];
    exp_t mon_e;
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev_valid = 1'b0;

    blu_inv #(.WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .ct_i        (ct_i),
        .x_i         (x_i),
        .y_i         (y_i),
        .q_i         (q_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .a_o         (a_o),
        .b_o         (b_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial forever begin
        @(posedge clk_i);
        edge_cnt++;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic recordFail(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: got timeout/none, expected event", name);
    endtask

    // Drives one request, waits (bounded) for acceptance and optionally queues its expected result.
    task automatic applyStimulus(input logic ct, input logic [2*W-1:0] x, input logic [2*W-1:0] y,
                                 input logic [W-1:0] q, input logic [W-1:0] ea, input logic [W-1:0] eb,
                                 input logic ee, input int lat, input bit push);
        int waited = 0;
        @(negedge clk_i);
        ct_i       = ct;
        x_i        = x;
        y_i        = y;
        q_i        = q;
        in_valid_i = 1'b1;
        while (!in_ready_o && waited < 200) begin
            @(negedge clk_i);
            waited++;
        end
        if (!in_ready_o) begin
            recordFail("accept_timeout");
        end else if (push) begin
            exp_q.push_back('{a: ea, b: eb, err: ee, lat: lat, acc: edge_cnt + 1});
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
    endtask

    task automatic waitDrain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 300) begin
            @(negedge clk_i);
            waited++;
        end
        if (exp_q.size() != 0) begin
            recordFail("drain_timeout");
            exp_q.delete();
        end
        @(negedge clk_i);
    endtask

    // Monitor samples 2 time units after the falling edge, once stimulus has settled.
    initial forever begin
        @(negedge clk_i);
        #2;
        if (!rst_i) begin
            if (out_valid_o && !prev_valid) begin
                if (exp_q.size() == 0) recordFail("unexpected_output");
                else checkOutput("latency", edge_cnt - exp_q[0].acc, exp_q[0].lat);
            end
            if (out_valid_o && out_ready_i && exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                checkOutput("result_a", a_o, mon_e.a);
                checkOutput("result_b", b_o, mon_e.b);
                checkOutput("result_err", err_o, mon_e.err);
            end
        end
        prev_valid = out_valid_o;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got time limit, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        ct_i        = 1'b0;
        x_i         = '0;
        y_i         = '0;
        q_i         = '0;
        repeat (3) @(negedge clk_i);
        checkOutput("reset_in_ready", in_ready_o, 1);
        checkOutput("reset_out_valid", out_valid_o, 0);
        checkOutput("reset_a", a_o, 0);
        checkOutput("reset_b", b_o, 0);
        checkOutput("reset_err", err_o, 0);
        rst_i = 1'b0;

        $display("[TB] CT and GS recovery");
        applyStimulus(1'b1, 16'd26, 16'hFFF0, 8'd7, 8'd5, 8'd3, 1'b0, 19, 1'b1);
        waitDrain();
        applyStimulus(1'b0, 16'd42, 16'd18, 8'd3, 8'd10, 8'd4, 1'b0, 35, 1'b1);
        waitDrain();

        $display("[TB] Backpressure with a pending second request");
        out_ready_i = 1'b0;
        applyStimulus(1'b0, 16'd55, 16'hFFDD, 8'd5, 8'd2, 8'd9, 1'b0, 35, 1'b1);
        waited = 0;
        while (!out_valid_o && waited < 100) begin
            @(negedge clk_i);
            waited++;
        end
        if (!out_valid_o) recordFail("valid_timeout");
        ct_i       = 1'b1;
        x_i        = 16'd26;
        y_i        = 16'hFFF0;
        q_i        = 8'd0;
        in_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checkOutput("hold_valid", out_valid_o, 1);
            checkOutput("hold_a", a_o, 2);
            checkOutput("hold_b", b_o, 9);
            checkOutput("hold_in_ready", in_ready_o, 0);
        end
        out_ready_i = 1'b1;
        applyStimulus(1'b1, 16'd26, 16'hFFF0, 8'd0, 8'd5, 8'hFF, 1'b1, 19, 1'b1);
        waitDrain();

        $display("[TB] Error paths");
        applyStimulus(1'b1, 16'd27, 16'hFFF0, 8'd7, 8'd5, 8'd3, ODD_ERR, 19, 1'b1);
        waitDrain();
        applyStimulus(1'b0, 16'd42, 16'd18, 8'd0, 8'hFF, 8'h00, 1'b1, 35, 1'b1);
        waitDrain();

        $display("[TB] Reset during division");
        applyStimulus(1'b0, 16'd42, 16'd18, 8'd3, 8'd0, 8'd0, 1'b0, 0, 1'b0);
        repeat (5) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("abort_in_ready", in_ready_o, 1);
        checkOutput("abort_out_valid", out_valid_o, 0);
        checkOutput("abort_a", a_o, 0);
        checkOutput("abort_b", b_o, 0);
        checkOutput("abort_err", err_o, 0);
        rst_i = 1'b0;
        applyStimulus(1'b1, 16'd26, 16'hFFF0, 8'd7, 8'd5, 8'd3, 1'b0, 19, 1'b1);
        waitDrain();
        applyStimulus(1'b0, 16'd55, 16'hFFDD, 8'd5, 8'd2, 8'd9, 1'b0, 35, 1'b1);
        waitDrain();

        repeat (3) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
